rv_branch_resolve: RTL and testbench
====================================

Name: rv_branch_resolve

Overview:
- Execute-stage consumer of the branch comparator's `branchTaken`.
- Computes the actual control-flow target for BEQ..BGEU, JAL and JALR, and compares it against the fetch-stage prediction.
- On mispredict: issues a registered PC redirect to fetch over a valid/ready handshake, then holds a multi-cycle flush of younger pipeline stages.
- Also emits a one-cycle predictor-update pulse for every resolved control-flow instruction.

Parameters:
- BUS_W, `BUS_W (shared include), datapath/PC width.
- FLUSH_CYCLES, 2, cycles `flush` stays high after the redirect is accepted; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- exValid  in  1  EX instruction valid.
- exReady  out  1  block can accept an instruction.
- isBranch  in  1  conditional branch.
- isJal  in  1  JAL.
- isJalr  in  1  JALR.
- branchTaken  in  1  comparator result; used only when isBranch.
- predTaken  in  1  fetch predicted taken.
- predTarget  in  BUS_W  fetch predicted target.
- pc  in  BUS_W  instruction PC.
- imm  in  BUS_W  sign-extended immediate.
- rs1  in  BUS_W  JALR base.
- redirectValid  out  1  redirect request.
- redirectReady  in  1  fetch accepts redirect.
- redirectPc  out  BUS_W  corrected PC.
- flush  out  1  kill younger stages.
- bpUpdValid  out  1  predictor update pulse.
- bpUpdPc  out  BUS_W  PC of the resolved instruction.
- bpUpdTaken  out  1  actual direction.
- bpUpdTarget  out  BUS_W  actual target.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous, active-low `rst_n`.
- Reset values: all outputs 0 except exReady=1; state IDLE; flush counter 0. Reset asserted mid-operation aborts any pending redirect or flush the same edge, with no further pulses.
- Accept condition: an instruction is accepted when exValid & exReady & (isBranch|isJal|isJalr). Any other exValid is ignored and causes no pulse.
- Actual direction: taken = isJal | isJalr | (isBranch & branchTaken).
- Actual target:
  - JALR: (rs1+imm) with bit0 cleared.
  - Otherwise: pc+imm.
  - Not taken: pc+4.
  - All sums are BUS_W-bit modulo (wrap-around, no carry out).
- Mispredict condition: taken != predTaken, or (taken & predTaken & target != predTarget). When not taken and not predicted, predTarget is ignored.
- Latency on accept (cycle N), outputs registered at edge N+1:
  - bpUpd* pulse for exactly one cycle.
  - If mispredict: redirectPc = actual next PC (target if taken, else pc+4), redirectValid=1, state -> REDIRECT.
  - Otherwise: remain IDLE.
- State machine:
  - IDLE: exReady=1.
  - REDIRECT: exReady=0; redirectValid and redirectPc held stable until redirectReady. On the handshake edge: redirectValid->0, flush->1, counter=FLUSH_CYCLES-1, state->FLUSH. flush rises on the same edge redirectValid falls.
  - FLUSH: exReady=0; flush=1; counter decrements each cycle. When counter==0, next edge: flush->0, state->IDLE.
- Ready before valid: redirectReady high before redirectValid has no effect.
- Handshake timing: a handshake in the first REDIRECT cycle is legal, giving minimum redirect-to-IDLE of 1+FLUSH_CYCLES cycles.
- Overflow: pc near 2^BUS_W with pc+4 wrapping still produces a valid redirect to the wrapped value.

Optional Feature:
- Macro: RVX_MISALIGN_TRAP_EN.
- Defined: adds outputs trapValid (1) and trapPc (BUS_W), reset 0.
  - If taken & target[1]!=0: no redirect; trapValid pulses one cycle at N+1; trapPc=pc; flush follows exactly as after a redirect (state FLUSH).
  - bpUpd still pulses.
- Undefined: no trap ports; target[1] passes through unchanged into redirectPc.

Decomposition:
- Shared include RVX_Info.v gains:
  - `BUS_W (already present);
  - state encodings RES_IDLE=2'd0, RES_REDIRECT=2'd1, RES_FLUSH=2'd2;
  - `PC_STEP=4.
- One natural sub-module: rv_target_gen. Purely combinational; produces taken, target, next-PC and mispredict from the decoded inputs.
- The FSM, counter and output registers stay in rv_branch_resolve.

Test Plan:
- BEQ taken, predTaken=0, pc=0x100, imm=0x20 -> edge N+1: redirectValid=1, redirectPc=0x120, bpUpdTaken=1; redirectReady held low for 3 cycles -> redirectPc stable, exReady=0.
- BNE not taken, predTaken=1, pc=0x200 -> redirectPc=0x204; redirectReady=1 immediately -> flush high exactly 2 cycles, then exReady=1.
- JAL correctly predicted: predTaken=1, predTarget=0x340, pc=0x300, imm=0x40 -> no redirect, no flush, single bpUpdValid pulse with bpUpdTarget=0x340.
- JALR rs1=0x1001, imm=0x10, predTarget=0x1010 -> target 0x1010 (bit0 cleared), no redirect; same case with predTarget=0x1014 -> redirectPc=0x1010.
- Wrap: pc=0xFFFFFFFC, BLT not taken, predTaken=1 -> redirectPc=0x00000000; rst_n low during FLUSH -> next edge flush=0, exReady=1, no residual pulses.
- With RVX_MISALIGN_TRAP_EN: BGE taken to 0x102 from pc=0x100 -> trapValid=1, trapPc=0x100, redirectValid stays 0, flush 2 cycles.

Source files
------------

// File: rtl/rv_branch_resolve_pkg.sv
// Shared types and constants for the branch-resolve slice.
// Datapath width, PC step, flush counter width and FSM state encodings.
package rv_branch_resolve_pkg;

   localparam int unsigned BusW   = 32;
   localparam int unsigned PcStep = 4;
   localparam int unsigned CntW   = 4;

   typedef enum logic [1:0] {
      ResIdle     = 2'd0,
      ResRedirect = 2'd1,
      ResFlush    = 2'd2
   } res_state_e;

endpackage

// File: rtl/rv_target_gen.sv
// Combinational control-flow resolution: actual direction, target, next PC
// and mispredict flag against the fetch-stage prediction.
module rv_target_gen
   import rv_branch_resolve_pkg::*;
#(
   parameter int unsigned BUS_W = BusW
) (
   input  logic             is_branch_i,
   input  logic             is_jal_i,
   input  logic             is_jalr_i,
   input  logic             branch_taken_i,
   input  logic             pred_taken_i,
   input  logic [BUS_W-1:0] pred_target_i,
   input  logic [BUS_W-1:0] pc_i,
   input  logic [BUS_W-1:0] imm_i,
   input  logic [BUS_W-1:0] rs1_i,
   output logic             taken_o,
   output logic [BUS_W-1:0] target_o,
   output logic [BUS_W-1:0] next_pc_o,
   output logic             mispredict_o
);

   logic [BUS_W-1:0] jalr_sum;

   assign jalr_sum = rs1_i + imm_i;
   assign taken_o  = is_jal_i | is_jalr_i | (is_branch_i & branch_taken_i);

   // JALR clears bit 0 of the computed address; everything else is pc-relative.
   assign target_o  = is_jalr_i ? {jalr_sum[BUS_W-1:1], 1'b0} : (pc_i + imm_i);
   assign next_pc_o = taken_o ? target_o : (pc_i + BUS_W'(PcStep));

   // Predicted target only matters when both sides agree the flow is taken.
   assign mispredict_o = (taken_o != pred_taken_i) |
                         (taken_o & pred_taken_i & (target_o != pred_target_i));

endmodule

// File: rtl/rv_branch_resolve.sv
// Execute-stage branch resolution: redirect handshake, multi-cycle flush and
// predictor update. Optional misaligned-target trap under RVX_MISALIGN_TRAP_EN.
module rv_branch_resolve
   import rv_branch_resolve_pkg::*;
#(
   parameter int unsigned BUS_W        = BusW,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             exValid,
   output logic             exReady,
   input  logic             isBranch,
   input  logic             isJal,
   input  logic             isJalr,
   input  logic             branchTaken,
   input  logic             predTaken,
   input  logic [BUS_W-1:0] predTarget,
   input  logic [BUS_W-1:0] pc,
   input  logic [BUS_W-1:0] imm,
   input  logic [BUS_W-1:0] rs1,
   output logic             redirectValid,
   input  logic             redirectReady,
   output logic [BUS_W-1:0] redirectPc,
   output logic             flush,
`ifdef RVX_MISALIGN_TRAP_EN
   output logic             trapValid,
   output logic [BUS_W-1:0] trapPc,
`endif
   output logic             bpUpdValid,
   output logic [BUS_W-1:0] bpUpdPc,
   output logic             bpUpdTaken,
   output logic [BUS_W-1:0] bpUpdTarget
);

   localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES - 1);

   logic             taken;
   logic             mispredict;
   logic [BUS_W-1:0] target;
   logic [BUS_W-1:0] next_pc;
   logic             accept;

   res_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             redirect_valid_q, redirect_valid_d;
   logic [BUS_W-1:0] redirect_pc_q, redirect_pc_d;
   logic             flush_q, flush_d;
   logic             bp_upd_valid_q, bp_upd_valid_d;
   logic [BUS_W-1:0] bp_upd_pc_q, bp_upd_pc_d;
   logic             bp_upd_taken_q, bp_upd_taken_d;
   logic [BUS_W-1:0] bp_upd_target_q, bp_upd_target_d;
`ifdef RVX_MISALIGN_TRAP_EN
   logic             trap_valid_q, trap_valid_d;
   logic [BUS_W-1:0] trap_pc_q, trap_pc_d;
`endif

   rv_target_gen #(
      .BUS_W (BUS_W)
   ) u_target_gen (
      .is_branch_i    (isBranch),
      .is_jal_i       (isJal),
      .is_jalr_i      (isJalr),
      .branch_taken_i (branchTaken),
      .pred_taken_i   (predTaken),
      .pred_target_i  (predTarget),
      .pc_i           (pc),
      .imm_i          (imm),
      .rs1_i          (rs1),
      .taken_o        (taken),
      .target_o       (target),
      .next_pc_o      (next_pc),
      .mispredict_o   (mispredict)
   );

   assign exReady = (state_q == ResIdle);
   assign accept  = exValid & exReady & (isBranch | isJal | isJalr);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = flush_q;
      bp_upd_valid_d   = 1'b0;
      bp_upd_pc_d      = bp_upd_pc_q;
      bp_upd_taken_d   = bp_upd_taken_q;
      bp_upd_target_d  = bp_upd_target_q;
`ifdef RVX_MISALIGN_TRAP_EN
      trap_valid_d     = 1'b0;
      trap_pc_d        = trap_pc_q;
`endif
      unique case (state_q)
         ResIdle: begin
            if (accept) begin
               bp_upd_valid_d  = 1'b1;
               bp_upd_pc_d     = pc;
               bp_upd_taken_d  = taken;
               bp_upd_target_d = taken ? target : next_pc;
`ifdef RVX_MISALIGN_TRAP_EN
               // A misaligned taken target traps instead of redirecting.
               if (taken & target[1]) begin
                  trap_valid_d = 1'b1;
                  trap_pc_d    = pc;
                  flush_d      = 1'b1;
                  cnt_d        = FlushInit;
                  state_d      = ResFlush;
               end else
`endif
               if (mispredict) begin
                  redirect_valid_d = 1'b1;
                  redirect_pc_d    = next_pc;
                  state_d          = ResRedirect;
               end
            end
         end
         ResRedirect: begin
            if (redirectReady) begin
               redirect_valid_d = 1'b0;
               flush_d          = 1'b1;
               cnt_d            = FlushInit;
               state_d          = ResFlush;
            end
         end
         ResFlush: begin
            if (cnt_q == '0) begin
               flush_d = 1'b0;
               state_d = ResIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d          = ResIdle;
            flush_d          = 1'b0;
            redirect_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ResIdle;
         cnt_q            <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         bp_upd_valid_q   <= 1'b0;
         bp_upd_pc_q      <= '0;
         bp_upd_taken_q   <= 1'b0;
         bp_upd_target_q  <= '0;
`ifdef RVX_MISALIGN_TRAP_EN
         trap_valid_q     <= 1'b0;
         trap_pc_q        <= '0;
`endif
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         bp_upd_valid_q   <= bp_upd_valid_d;
         bp_upd_pc_q      <= bp_upd_pc_d;
         bp_upd_taken_q   <= bp_upd_taken_d;
         bp_upd_target_q  <= bp_upd_target_d;
`ifdef RVX_MISALIGN_TRAP_EN
         trap_valid_q     <= trap_valid_d;
         trap_pc_q        <= trap_pc_d;
`endif
      end
   end

   assign redirectValid = redirect_valid_q;
   assign redirectPc    = redirect_pc_q;
   assign flush         = flush_q;
   assign bpUpdValid    = bp_upd_valid_q;
   assign bpUpdPc       = bp_upd_pc_q;
   assign bpUpdTaken    = bp_upd_taken_q;
   assign bpUpdTarget   = bp_upd_target_q;
`ifdef RVX_MISALIGN_TRAP_EN
   assign trapValid     = trap_valid_q;
   assign trapPc        = trap_pc_q;
`endif

endmodule

// File: tb/tb_rv_branch_resolve.sv
// Scoreboard bench for rv_branch_resolve: directed cases plus random traffic
// against a transaction-level model of availability, redirects and updates.
module tb_rv_branch_resolve;

   localparam int unsigned W     = 32;
   localparam int unsigned FLUSH = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         exValid = 1'b0, isBranch = 1'b0, isJal = 1'b0, isJalr = 1'b0;
   logic         branchTaken = 1'b0, predTaken = 1'b0, redirectReady = 1'b0;
   logic [W-1:0] predTarget = '0, pc = '0, imm = '0, rs1 = '0;
   logic         exReady, redirectValid, flush, bpUpdValid, bpUpdTaken;
   logic [W-1:0] redirectPc, bpUpdPc, bpUpdTarget;
`ifdef RVX_MISALIGN_TRAP_EN
   logic         trapValid;
   logic [W-1:0] trapPc;
`endif

   rv_branch_resolve #(
      .BUS_W        (W),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .exValid       (exValid),
      .exReady       (exReady),
      .isBranch      (isBranch),
      .isJal         (isJal),
      .isJalr        (isJalr),
      .branchTaken   (branchTaken),
      .predTaken     (predTaken),
      .predTarget    (predTarget),
      .pc            (pc),
      .imm           (imm),
      .rs1           (rs1),
      .redirectValid (redirectValid),
      .redirectReady (redirectReady),
      .redirectPc    (redirectPc),
      .flush         (flush),
`ifdef RVX_MISALIGN_TRAP_EN
      .trapValid     (trapValid),
      .trapPc        (trapPc),
`endif
      .bpUpdValid    (bpUpdValid),
      .bpUpdPc       (bpUpdPc),
      .bpUpdTaken    (bpUpdTaken),
      .bpUpdTarget   (bpUpdTarget)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] pc;
      logic         taken;
      logic [W-1:0] tgt;
   } bp_t;

   bp_t          bp_q[$];
   logic [W-1:0] rd_q[$];
   logic [W-1:0] tr_q[$];

   // Model of block availability: 0 free, 1 awaiting redirect accept, 2 flushing.
   int           phase = 0;
   int           flush_left = 0;
   int           total = 0;
   int           bad = 0;
   bit           done = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void resolve(input logic br, input logic jal, input logic jalr,
                                   input logic bt, input logic [W-1:0] pcv,
                                   input logic [W-1:0] immv, input logic [W-1:0] rs1v,
                                   output logic tk, output logic [W-1:0] tgt,
                                   output logic [W-1:0] nxt);
      tk = jal | jalr | (br & bt);
      if (jalr) tgt = (rs1v + immv) & 32'hFFFF_FFFE;
      else      tgt = pcv + immv;
      nxt = tk ? tgt : pcv + 32'd4;
   endfunction

   // Drive one cycle and predict what the following rising edge does.
   task automatic step(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic bt, input logic pt, input logic [W-1:0] ptgt,
                       input logic [W-1:0] pcv, input logic [W-1:0] immv,
                       input logic [W-1:0] rs1v, input logic rr, input logic rst);
      logic         tk, misp, trap;
      logic [W-1:0] tgt, nxt;
      @(negedge clk);
      exValid = v; isBranch = br; isJal = jal; isJalr = jalr; branchTaken = bt;
      predTaken = pt; predTarget = ptgt; pc = pcv; imm = immv; rs1 = rs1v;
      redirectReady = rr; rst_n = rst;
      if (!rst) begin
         phase = 0;
         flush_left = 0;
      end else if (phase == 0) begin
         if (v && (br || jal || jalr)) begin
            resolve(br, jal, jalr, bt, pcv, immv, rs1v, tk, tgt, nxt);
            misp = (tk != pt) || (tk && tgt != ptgt);
            trap = 1'b0;
`ifdef RVX_MISALIGN_TRAP_EN
            trap = tk && tgt[1];
`endif
            bp_q.push_back('{pc: pcv, taken: tk, tgt: nxt});
            if (trap) begin
               tr_q.push_back(pcv);
               phase = 2;
               flush_left = FLUSH;
            end else if (misp) begin
               rd_q.push_back(nxt);
               phase = 1;
            end
         end
      end else if (phase == 1) begin
         if (rr) begin
            phase = 2;
            flush_left = FLUSH;
         end
      end else begin
         flush_left--;
         if (flush_left == 0) phase = 0;
      end
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rr, 1'b1);
   endtask

   // Monitor: level checks against the model plus scoreboard pops on output events.
   initial begin
      logic         rv_prev;
      logic [W-1:0] held_pc;
      bp_t          e;
      rv_prev = 1'b0;
      held_pc = '0;
      @(posedge clk);
      while (!done) begin
         #1;
         check("ex_ready", exReady, (phase == 0));
         check("flush", flush, (phase == 2));
         check("redirect_valid", redirectValid, (phase == 1));
         if (bpUpdValid) begin
            if (bp_q.size() == 0) begin
               check("bp_upd_unexpected", bpUpdValid, 1'b0);
            end else begin
               e = bp_q.pop_front();
               check("bp_upd_pc", bpUpdPc, e.pc);
               check("bp_upd_taken", bpUpdTaken, e.taken);
               check("bp_upd_target", bpUpdTarget, e.tgt);
            end
         end
         if (redirectValid && !rv_prev) begin
            if (rd_q.size() == 0) check("redirect_unexpected", redirectValid, 1'b0);
            else check("redirect_pc", redirectPc, rd_q.pop_front());
            held_pc = redirectPc;
         end else if (redirectValid) begin
            check("redirect_pc_stable", redirectPc, held_pc);
         end
         rv_prev = redirectValid;
`ifdef RVX_MISALIGN_TRAP_EN
         if (trapValid) begin
            if (tr_q.size() == 0) check("trap_unexpected", trapValid, 1'b0);
            else check("trap_pc", trapPc, tr_q.pop_front());
         end
`endif
         @(posedge clk);
      end
   end

   initial begin
      logic [W-1:0] rpc, rimm, rrs1, rptgt, tgt, nxt;
      logic         tk, bt, pt, br, jal, jalr, v, rr;
      int           sel;
      step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
      step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
      idle(1'b0);
      // BEQ taken, predicted not taken; redirect held while fetch stalls.
      step(1, 1, 0, 0, 1, 0, '0, 32'h100, 32'h20, '0, 0, 1);
      repeat (3) idle(1'b0);
      idle(1'b1);
      repeat (3) idle(1'b0);
      // BNE not taken, predicted taken; ready-before-valid then immediate accept.
      step(1, 1, 0, 0, 0, 1, 32'h999, 32'h200, 32'h8, '0, 1, 1);
      idle(1'b1);
      repeat (3) idle(1'b0);
      // JAL correctly predicted.
      step(1, 0, 1, 0, 0, 1, 32'h340, 32'h300, 32'h40, '0, 0, 1);
      idle(1'b0);
      // JALR bit-0 clearing, first correct then mispredicted target.
      step(1, 0, 0, 1, 0, 1, 32'h1010, 32'h500, 32'h10, 32'h1001, 0, 1);
      step(1, 0, 0, 1, 0, 1, 32'h1014, 32'h500, 32'h10, 32'h1001, 0, 1);
      idle(1'b1);
      repeat (3) idle(1'b0);
      // BGE taken to a halfword-aligned target.
      step(1, 1, 0, 0, 1, 0, '0, 32'h100, 32'h2, '0, 0, 1);
      idle(1'b1);
      repeat (3) idle(1'b0);
      // Fall-through wrap, then reset while flushing.
      step(1, 1, 0, 0, 0, 1, 32'h40, 32'hFFFF_FFFC, 32'h8, '0, 0, 1);
      idle(1'b1);
      step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
      repeat (3) idle(1'b0);
      // Random traffic, including instructions offered while busy.
      for (int i = 0; i < 3000; i++) begin
         sel  = $urandom_range(0, 4);
         br   = (sel == 1) || (sel == 4);
         jal  = (sel == 2);
         jalr = (sel == 3);
         v    = ($urandom_range(0, 3) != 0);
         bt   = $urandom_range(0, 1);
         rr   = ($urandom_range(0, 2) == 0);
         rpc  = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                            : ($urandom & 32'hFFFF_FFFC);
         rimm = $urandom_range(0, 4095);
         rimm = {{20{rimm[11]}}, rimm[11:1], 1'b0};
         rrs1 = $urandom;
         resolve(br, jal, jalr, bt, rpc, rimm, rrs1, tk, tgt, nxt);
         pt    = ($urandom_range(0, 2) != 0) ? tk : ~tk;
         rptgt = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
         step(v, br, jal, jalr, bt, pt, rptgt, rpc, rimm, rrs1, rr, 1'b1);
      end
      idle(1'b1);
      repeat (FLUSH + 4) idle(1'b0);
      done = 1'b1;
      @(posedge clk);
      #2;
      check("bp_q_drained", bp_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      check("tr_q_drained", tr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
